clcd_init_sequencer: RTL

//  Sequences the CLCD signal generator (I2C backpack, HD44780 4-bit mode). After reset it

---
 rtl/clcd_init_sequencer_pkg.sv | 31 +++
 rtl/clcd_us_tick.sv | 31 +++
 rtl/clcd_init_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clcd_init_sequencer_pkg.sv
// Shared types and HD44780 constants for the CLCD init/command sequencer.
package clcd_init_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_ISSUE = 3'd1,
    S_WBUSY = 3'd2,
    S_WDONE = 3'd3,
    S_DELAY = 3'd4,
    S_READY = 3'd5
  } state_t;

  // HD44780 command bytes (4-bit bus via I2C backpack)
  localparam logic [7:0] WAKE_8BIT    = 8'h33;
  localparam logic [7:0] WAKE_4BIT    = 8'h32;
  localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] HOME         = 8'h02;
  localparam logic [7:0] ENTRY_INC    = 8'h06;

  localparam int         INIT_ROM_LEN = 6;
  localparam logic [2:0] ROM_LAST     = 3'(INIT_ROM_LEN - 1);

  // Clear and home are the slow instructions; everything else uses the short wait.
  function automatic logic needs_long_delay(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR) || (data == HOME));
  endfunction

endpackage

// File: rtl/clcd_us_tick.sv
// Free-running 1 us prescaler: one-cycle tick every CLK_FREQ_HZ/1e6 clocks.
module clcd_us_tick #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Prescaler counter; tick is registered so downstream logic sees a clean pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clcd_init_sequencer.sv
// Plays the HD44780 power-on init ROM, then forwards single-byte user requests to the
// CLCD signal generator, one at a time, enforcing the post-byte execution delay.
module clcd_init_sequencer
  import clcd_init_sequencer_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int POWER_ON_MS    = 40,
  parameter int CMD_DELAY_US   = 50,
  parameter int CLEAR_DELAY_US = 2000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  input  logic       gen_busy,
  output logic       gen_valid,
  output logic       gen_rs,
  output logic       gen_rw,
  output logic [7:0] gen_data
);

  localparam int PWR_TICKS = POWER_ON_MS * 1000;
  localparam int MAX_A     = (PWR_TICKS > CLEAR_DELAY_US) ? PWR_TICKS : CLEAR_DELAY_US;
  localparam int MAX_TICKS = (MAX_A > CMD_DELAY_US) ? MAX_A : CMD_DELAY_US;
  // Counter runs one past the target on the exit tick, so leave room for MAX_TICKS+1.
  localparam int DW        = $clog2(MAX_TICKS + 2);

  state_t          state, state_nxt;
  logic            tick;
  logic [DW-1:0]   dly_cnt;
  logic [DW-1:0]   dly_target;
  logic            delay_hit;
  logic [2:0]      rom_idx;
  logic [2:0]      rom_sel;
  logic [7:0]      byte_q;
  logic            rs_q;
  logic            load_rom;
  logic            load_req;
  logic            adv_idx;
  logic            set_done;

  // Power-on init ROM
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return WAKE_8BIT;
      3'd1:    return WAKE_4BIT;
      3'd2:    return FUNC_4BIT_2L;
      3'd3:    return DISP_ON;
      3'd4:    return CLEAR;
      3'd5:    return ENTRY_INC;
      default: return 8'h00;
    endcase
  endfunction

  clcd_us_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_us_tick (
    .clk    (clk),
    .reset_p(reset_p),
    .tick   (tick)
  );

  // The first tick after entering a wait may be a partial microsecond, so a wait of N us
  // completes on tick N+1; that guarantees at least N full microseconds elapse.
  always_comb begin
    if (state == S_PWR)                    dly_target = DW'(PWR_TICKS);
    else if (needs_long_delay(rs_q, byte_q)) dly_target = DW'(CLEAR_DELAY_US);
    else                                   dly_target = DW'(CMD_DELAY_US);
  end

  assign delay_hit = tick && (dly_cnt == dly_target);
  assign rom_sel   = adv_idx ? rom_idx + 3'd1 : rom_idx;

  assign gen_data  = byte_q;
  assign gen_rs    = rs_q;
  assign gen_rw    = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset_p) state <= S_PWR;
    else         state <= state_nxt;
  end

  // Next-state decode plus the Moore/Mealy strobes driving the datapath.
  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    gen_valid = 1'b0;
    req_ready = 1'b0;
    load_rom  = 1'b0;
    load_req  = 1'b0;
    adv_idx   = 1'b0;
    set_done  = 1'b0;
    case (state)
      S_PWR: begin
        if (delay_hit) begin
          load_rom  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!gen_busy) begin
          gen_valid = 1'b1;
          state_nxt = S_WBUSY;
        end
      end
      S_WBUSY: begin
        if (gen_busy) state_nxt = S_WDONE;
      end
      S_WDONE: begin
        if (!gen_busy) state_nxt = S_DELAY;
      end
      S_DELAY: begin
        if (delay_hit) begin
          if (init_done) begin
            state_nxt = S_READY;
          end else if (rom_idx != ROM_LAST) begin
            adv_idx   = 1'b1;
            load_rom  = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            set_done  = 1'b1;
            state_nxt = S_READY;
          end
        end
      end
      S_READY: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_req  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      default: state_nxt = S_PWR;
    endcase
  end

  // Byte/RS holding registers, ROM index, sticky init flag and the tick-based wait counter.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
      rom_idx   <= 3'd0;
      init_done <= 1'b0;
      dly_cnt   <= '0;
    end else begin
      if (load_req) begin
        byte_q <= req_data;
        rs_q   <= req_rs;
      end else if (load_rom) begin
        byte_q <= init_rom(rom_sel);
        rs_q   <= 1'b0;
      end
      if (adv_idx)  rom_idx   <= rom_idx + 3'd1;
      if (set_done) init_done <= 1'b1;
      if ((state == S_PWR) || (state == S_DELAY)) begin
        if (tick) dly_cnt <= dly_cnt + 1'b1;
      end else begin
        dly_cnt <= '0;
      end
    end
  end

endmodule
